// File: rtl/sevseg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// sevseg_scan_driver_if
// Bundles the display driver's data inputs and its board-pin outputs.
//   enable       : 1 = display on, 0 = all digits dark (scan keeps running)
//   value        : packed hex digits, nibble i = digit i, digit 0 rightmost
//   dp           : per-digit decimal point request, 1 = lit
//   blank_zeros  : 1 = suppress leading zero digits
//   brightness   : PWM duty select, 0 = off, 15 = full
//   anode_select : active-low anode enables
//   segs         : active-low segments, segs[0]=a ... segs[6]=g
//   dp_n         : active-low decimal point
//   frame_done   : one-cycle pulse at the end of each full scan
// master = the logic feeding the display, slave = the scan driver.
// ---------------------------------------------------------------------------
interface sevseg_scan_driver_if #(
    parameter int N_DIGITS = 8
);
    logic                    enable;
    logic [4*N_DIGITS-1:0]   value;
    logic [N_DIGITS-1:0]     dp;
    logic                    blank_zeros;
    logic [3:0]              brightness;
    logic [N_DIGITS-1:0]     anode_select;
    logic [6:0]              segs;
    logic                    dp_n;
    logic                    frame_done;

    modport master (
        output enable, value, dp, blank_zeros, brightness,
        input  anode_select, segs, dp_n, frame_done
    );

    modport slave (
        input  enable, value, dp, blank_zeros, brightness,
        output anode_select, segs, dp_n, frame_done
    );
endinterface

// File: rtl/sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sevseg_scan_driver
// Multiplexed common-anode seven-segment scanner with frame-synchronous value
// latching, leading-zero blanking, per-digit decimal points and 16-step PWM.
//   clock : system clock
//   reset : asynchronous, active-low
//   bus   : sevseg_scan_driver_if.slave (data inputs, anode/segment outputs)
// Each digit slot lasts SLOT_CYCLES clocks and is split into 16 PWM phases of
// SUB_CYCLES clocks. SLOT_CYCLES must be a multiple of 16 and at least 32;
// N_DIGITS must be 1..16 and match the interface instance.
// ---------------------------------------------------------------------------
module sevseg_scan_driver #(
    parameter int N_DIGITS    = 8,
    parameter int SLOT_CYCLES = 200000
) (
    input  logic                 clock,
    input  logic                 reset,
    sevseg_scan_driver_if.slave  bus
);
    localparam int SUB_CYCLES = SLOT_CYCLES / 16;
    localparam int SUB_W      = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    localparam int IDX_W      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    // Active-low g..a pattern for one hex digit.
    function automatic logic [6:0] enc(input logic [3:0] hex);
        case (hex)
            4'h0: enc = 7'b1000000;
            4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;
            4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;
            4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;
            4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b0000011;
            4'hC: enc = 7'b1000110;
            4'hD: enc = 7'b0100001;
            4'hE: enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    logic [SUB_W-1:0]      sub_cnt;
    logic [3:0]            phase;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] shadow_value;
    logic [N_DIGITS-1:0]   shadow_dp;

    logic sub_tick, slot_tick, last_digit, frame_tick;

    assign sub_tick   = (sub_cnt == SUB_W'(SUB_CYCLES - 1));
    assign slot_tick  = sub_tick && (phase == 4'hF);
    assign last_digit = (idx == IDX_W'(N_DIGITS - 1));
    assign frame_tick = slot_tick && last_digit;

    // Scan counters and frame shadow. The shadow only moves at the frame
    // boundary, so a whole scan always shows one consistent value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sub_cnt      <= '0;
            phase        <= '0;
            idx          <= '0;
            shadow_value <= '0;
            shadow_dp    <= '0;
        end else begin
            sub_cnt <= sub_tick ? '0 : sub_cnt + 1'b1;
            if (sub_tick)
                phase <= phase + 1'b1;
            // Explicit wrap so non-power-of-2 digit counts work.
            if (slot_tick)
                idx <= last_digit ? '0 : idx + 1'b1;
            if (frame_tick) begin
                shadow_value <= bus.value;
                shadow_dp    <= bus.dp;
            end
        end
    end

    // ---- stage p0: decode current digit from scan state ----
    // zero_from_p0[i] = shadow nibbles i..N_DIGITS-1 are all zero.
    logic [N_DIGITS-1:0] zero_from_p0;
    logic [3:0]          nib_p0;
    logic                blank_p0;
    logic                lit_p0;

    always_comb begin
        zero_from_p0 = '0;
        zero_from_p0[N_DIGITS-1] = (shadow_value[4*(N_DIGITS-1) +: 4] == 4'h0);
        for (int i = N_DIGITS - 2; i >= 0; i--)
            zero_from_p0[i] = zero_from_p0[i+1] && (shadow_value[4*i +: 4] == 4'h0);
    end

    assign nib_p0   = shadow_value[4*idx +: 4];
    // Digit 0 is never blanked so a zero value still shows one "0".
    assign blank_p0 = bus.blank_zeros && (idx != '0) && zero_from_p0[idx];
    // Brightness 15 is full on; otherwise lit for the first `brightness` phases.
    assign lit_p0   = bus.enable && ((bus.brightness == 4'hF) || (phase < bus.brightness));

    // ---- stage p1: registered pin drivers ----
    logic [N_DIGITS-1:0] anode_p1;
    logic [6:0]          segs_p1;
    logic                dp_n_p1;
    logic                frame_done_p1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode_p1      <= '1;
            segs_p1       <= 7'h7F;
            dp_n_p1       <= 1'b1;
            frame_done_p1 <= 1'b0;
        end else begin
            anode_p1      <= lit_p0 ? ~(N_DIGITS'(1) << idx) : '1;
            segs_p1       <= (lit_p0 && !blank_p0) ? enc(nib_p0) : 7'h7F;
            dp_n_p1       <= !(lit_p0 && shadow_dp[idx]);
            frame_done_p1 <= frame_tick;
        end
    end

    assign bus.anode_select = anode_p1;
    assign bus.segs         = segs_p1;
    assign bus.dp_n         = dp_n_p1;
    assign bus.frame_done   = frame_done_p1;
endmodule

// File: tb/tb_sevseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sevseg_scan_driver
// Drives sevseg_scan_driver (N_DIGITS=4, SLOT_CYCLES=32) with directed and
// randomized input settings and compares every output pin, every cycle,
// against a time-based reference model: the model derives digit index, PWM
// phase and frame boundary from the number of clock edges since reset.
// ---------------------------------------------------------------------------
module tb_sevseg_scan_driver;
    localparam int ND    = 4;
    localparam int SC    = 32;
    localparam int SUBC  = SC / 16;
    localparam int FRAME = ND * SC;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sevseg_scan_driver_if #(.N_DIGITS(ND)) bus ();

    sevseg_scan_driver #(
        .N_DIGITS   (ND),
        .SLOT_CYCLES(SC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int tcount = 0;
    logic [15:0] sh_val = '0;
    logic [3:0]  sh_dp  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, tcount);
        end
    endtask

    function automatic logic [6:0] seg_code(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return tbl[h];
    endfunction

    task automatic set_in(input logic [15:0] v, input logic [3:0] d, input logic bz,
                          input logic [3:0] br, input logic en);
        bus.value       = v;
        bus.dp          = d;
        bus.blank_zeros = bz;
        bus.brightness  = br;
        bus.enable      = en;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anode"}, 32'(bus.anode_select), 32'hF);
        check({tag, "_segs"},  32'(bus.segs),         32'h7F);
        check({tag, "_dpn"},   32'(bus.dp_n),         32'h1);
        check({tag, "_fd"},    32'(bus.frame_done),   32'h0);
    endtask

    // One clock edge: model what the outputs must be afterwards, then compare.
    task automatic step();
        int n, di, ph;
        logic en, bz, lit, blank, e_dpn, e_fd;
        logic [3:0] br, d, nib, e_an;
        logic [15:0] v;
        logic [6:0] e_seg;
        @(posedge clock);
        en = bus.enable; br = bus.brightness; bz = bus.blank_zeros;
        v  = bus.value;  d  = bus.dp;
        tcount++;
        n  = tcount - 1;               // scan position the outputs reflect
        di = (n / SC) % ND;
        ph = (n / SUBC) % 16;
        nib   = sh_val[4*di +: 4];
        blank = bz && (di != 0) && ((sh_val >> (4*di)) == 16'h0);
        lit   = en && (br == 4'hF || ph < int'(br));
        e_an  = lit ? ~(4'b0001 << di) : 4'hF;
        e_seg = (lit && !blank) ? seg_code(nib) : 7'h7F;
        e_dpn = !(lit && sh_dp[di]);
        e_fd  = ((n % FRAME) == FRAME - 1);
        if (e_fd) begin
            sh_val = v;
            sh_dp  = d;
        end
        #1;
        check("anode", 32'(bus.anode_select), 32'(e_an));
        check("segs",  32'(bus.segs),         32'(e_seg));
        check("dp_n",  32'(bus.dp_n),         32'(e_dpn));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
        check("one_anode", 32'($countones(~bus.anode_select) <= 1), 32'h1);
    endtask

    task automatic run(input int cycles);
        repeat (cycles) step();
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset  = 1'b1;
        tcount = 0;
        sh_val = '0;
        sh_dp  = '0;
    endtask

    initial begin
        logic [15:0] rv;
        reset = 1'b0;
        set_in(16'h12AF, 4'b0000, 1'b0, 4'hF, 1'b1);
        #23;
        check_reset_outputs("rst");
        release_reset();

        // 1: first frame shows zeros, then F,A,2,1
        run(2 * FRAME);

        // 2: leading-zero blanking, then zero value
        set_in(16'h0050, 4'b0000, 1'b1, 4'hF, 1'b1);
        run(2 * FRAME);
        set_in(16'h0000, 4'b0000, 1'b1, 4'hF, 1'b1);
        run(2 * FRAME);

        // 3: PWM at quarter duty, then off for a whole frame
        set_in(16'h1234, 4'b0000, 1'b0, 4'd4, 1'b1);
        run(FRAME);
        set_in(16'h1234, 4'b0000, 1'b0, 4'd0, 1'b1);
        run(FRAME);

        // 4: value change mid-frame (while idx=1) stays hidden until the next frame
        set_in(16'h1111, 4'b0000, 1'b0, 4'hF, 1'b1);
        run(FRAME + SC + 5);
        bus.value = 16'h2222;
        run(2 * FRAME);

        // 5: enable dropped mid-slot, frame_done keeps pulsing
        run(13);
        bus.enable = 1'b0;
        run(2 * FRAME + 7);
        bus.enable = 1'b1;
        run(SC);

        // 6: decimal point on digit 2, then asynchronous reset mid-slot
        set_in(16'h8765, 4'b0100, 1'b0, 4'hF, 1'b1);
        run(2 * FRAME + 17);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #12;
        check_reset_outputs("rst_hold");
        release_reset();
        run(FRAME + 9);

        // randomized settings with occasional mid-frame changes
        for (int k = 0; k < 16; k++) begin
            rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
            set_in(rv, 4'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom),
                   ($urandom_range(0, 5) != 0));
            run($urandom_range(20, 220));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
Parametrised multiplexed seven-segment driver. It is the next generation of the fixed 8-digit SevSegDisplay path. It scans N_DIGITS common-anode digits from one packed hex value and adds:
- frame-synchronous value latching (no tearing)
- leading-zero blanking
- per-digit decimal points
- 16-step PWM brightness

It sits between the counter/datapath logic and the board anode/segment pins in top.

Parameters:
N_DIGITS, 8, number of digits scanned (1..16)
SLOT_CYCLES, 200000, clock cycles per digit slot (0.002 s at 100 MHz); must be a multiple of 16, minimum 32
SUB_CYCLES, SLOT_CYCLES/16 (derived, localparam), clock cycles per PWM phase

Ports:
clock  in  1  system clock (100 MHz on board)
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = display on; 0 = all digits dark, scan keeps running
value  in  4*N_DIGITS  packed hex digits; nibble i = digit i, digit 0 is rightmost
dp  in  N_DIGITS  decimal point request per digit, 1 = lit
blank_zeros  in  1  1 = suppress leading zero digits
brightness  in  4  PWM duty select, 0 = off, 15 = full
anode_select  out  N_DIGITS  active-low anode enables
segs  out  7  active-low segments; segs[0]=a ... segs[6]=g
dp_n  out  1  active-low decimal point
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (reset=0, async): all counters 0, shadow value and shadow dp cleared, anode_select all 1s, segs 7'h7F, dp_n 1, frame_done 0.
- sub_cnt: counts 0..SUB_CYCLES-1 and wraps. sub_tick = (sub_cnt==SUB_CYCLES-1).
- phase: 4-bit, increments on sub_tick, wraps 15->0. slot_tick = sub_tick && phase==15.
- idx: $clog2(N_DIGITS) bits, minimum 1. Increments on slot_tick and wraps N_DIGITS-1 -> 0. Non-power-of-2 N_DIGITS must wrap explicitly.
- Frame latch: on slot_tick with idx==N_DIGITS-1, shadow value <= value and shadow dp <= dp, in the same cycle frame_done=1.
  - Input changes mid-frame are invisible until the next frame.
  - The first frame after reset displays zeros.
- Digit select: nib = shadow_value[4*idx +: 4].
- Blanking: digit idx is blank when blank_zeros=1, idx!=0, and shadow nibbles idx..N_DIGITS-1 are all zero.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A blank digit drives segs 7'h7F, but its dp is still honoured and its anode still asserts.
- PWM: lit = enable && (brightness==15 || phase < brightness).
  - brightness 0 -> never lit; 8 -> 8/16 phases; 15 -> 16/16.
- Output register: all outputs are registered, 1 cycle latency from internal idx/phase.
  - anode_select = lit ? ~(1<<idx) : all 1s.
  - segs = (lit && !blank) ? enc(nib) : 7'h7F.
  - dp_n = !(lit && shadow_dp[idx]).
  - At most one anode bit is 0 at any time.
- Encoding enc(), active-low g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Runtime changes: enable and brightness are sampled every cycle, unlatched; a change takes effect on the outputs 1 cycle later.
- Reset mid-scan: outputs go to reset values immediately (async). Scan restarts at idx 0, phase 0.

Test Plan:
(bench: N_DIGITS=4, SLOT_CYCLES=32, SUB_CYCLES=2)
1. Release reset, value=16'h12AF, brightness=15, enable=1, blank_zeros=0:
   - First frame: all segs 1000000 ("0"). frame_done pulses at cycle 127.
   - Next frame: anodes 1110->1101->1011->0111, each held 32 cycles, segs F,A,2,1 codes.
2. value=16'h0050, blank_zeros=1:
   - Digits 3,2: anode asserted, segs 7'h7F.
   - Digits 1,0: segs 0010010 ("5") then 1000000 ("0").
   - value=0 -> only digit 0 shows "0".
3. brightness=4:
   - Each 32-cycle slot: anode low for exactly the first 8 cycles (phases 0-3).
   - brightness=0 -> anode_select stays 4'hF for a whole frame.
4. Change value from 16'h1111 to 16'h2222 while idx=1:
   - Remaining digits of that frame still show "1".
   - "2" appears from the first slot after frame_done.
5. enable=0 mid-slot:
   - 1 cycle later: anode_select=4'hF, segs=7'h7F, dp_n=1.
   - frame_done keeps pulsing every 128 cycles.
6. dp=4'b0100, brightness=15: dp_n=0 only while anode_select=1011. Assert reset mid-slot: all outputs return to reset values immediately, without a clock edge.
